aes_iter_ctrl: RTL and testbench

Iterative AES-128 encryption controller that time-multiplexes a single `Round` instance and a single `last_round` instance over ten cycles, instead of instantiating ten unrolled rounds. It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey itself. It then sequences round index, state and round key into the shared datapath, and presents the ciphertext on a valid/ready output. It sits between the bus-side request logic and the round datapath cells.

---
 rtl/aes_iter_ctrl.sv | 107 ++++++++++
 tb/tb_aes_iter_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryption controller: drives one shared Round/last_round
// datapath for ten cycles per block behind valid/ready handshakes.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a plaintext/key pair; initial AddRoundKey on accept
//   RUN   | cnt_q 0..8 feeds Round; cnt_q 9 feeds last_round into res_q
//   DONE  | ciphertext presented on out_data until out_ready
module aes_iter_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  input  logic         flush,
  output logic         busy,
  output logic [3:0]   rnd_index,
  output logic [127:0] rnd_data,
  output logic [127:0] rnd_key,
  input  logic [127:0] rnd_data_out,
  input  logic [127:0] rnd_key_out,
  input  logic [127:0] last_data_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [3:0]   cnt_q;
  logic [127:0] res_q;

  assign rnd_data  = state_q;
  assign rnd_key   = key_q;
  assign rnd_index = (fsm_q == RUN) ? cnt_q : 4'd0;
  assign out_data  = res_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      // flush outranks acceptance and drops any block in flight
      fsm_q     <= IDLE;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= in_data ^ in_key;
            key_q    <= in_key;
            cnt_q    <= '0;
            fsm_q    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q < 4'd9) begin
            state_q <= rnd_data_out;
            key_q   <= rnd_key_out;
            cnt_q   <= cnt_q + 4'd1;
          end else if (cnt_q == 4'd9) begin
            res_q     <= last_data_out;
            fsm_q     <= DONE;
            out_valid <= 1'b1;
          end else begin
            // corrupted round count: abandon the block
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm_q     <= IDLE;
          cnt_q     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: models the Round/last_round cells and scores
// ciphertexts against published AES-128 vectors.
module tb_aes_iter_ctrl;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         flush;
  logic         busy;
  logic [3:0]   rnd_index;
  logic [127:0] rnd_data;
  logic [127:0] rnd_key;
  logic [127:0] rnd_data_out;
  logic [127:0] rnd_key_out;
  logic [127:0] last_data_out;
  logic [127:0] next_key;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int hs_cyc   = 0;
  int a0, a1;
  logic [127:0] sb[$];

  aes_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .busy(busy),
    .rnd_index(rnd_index), .rnd_data(rnd_data), .rnd_key(rnd_key),
    .rnd_data_out(rnd_data_out), .rnd_key_out(rnd_key_out),
    .last_data_out(last_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // GF(2^8) and AES round primitives for the datapath model
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] e;
    r = 8'h01;
    x = a;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, x);
      x = gmul(x, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixcol(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign next_key      = expand(rnd_key, rcon(rnd_index));
  assign rnd_key_out   = next_key;
  assign rnd_data_out  = mixc(sub_shift(rnd_data)) ^ next_key;
  assign last_data_out = sub_shift(rnd_data) ^ next_key;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // output side of the scoreboard
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out_valid", 128'(out_valid), 128'(0));
      else chk("ciphertext", out_data, sb.pop_front());
      hs_cyc = cyc + 1;
    end
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic offer(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    for (int i = 0; i < 60; i++) begin
      if (in_ready && !flush && rst_n) begin
        sb.push_back(exp);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
  endtask

  // follows one RUN phase and the first DONE cycle
  task automatic track();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rnd_index", 128'(rnd_index), 128'(k));
      chk("busy_run", 128'(busy), 128'(1));
      chk("in_ready_run", 128'(in_ready), 128'(0));
      chk("out_valid_early", 128'(out_valid), 128'(0));
      @(posedge clk);
    end
    @(negedge clk);
    chk("out_valid_latency", 128'(out_valid), 128'(1));
    chk("busy_done", 128'(busy), 128'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rnd_index", 128'(rnd_index), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_rnd_data", rnd_data, 128'(0));
    chk("rst_rnd_key", rnd_key, 128'(0));
    rst_n = 1'b1;

    // single block, then back-to-back
    out_ready = 1'b1;
    offer(PT1, K1, CT1);
    a0 = acc_cyc;
    chk("initial_ark", rnd_data, PT1 ^ K1);
    chk("initial_key", rnd_key, K1);
    track();
    offer(PT2, K2, CT2);
    a1 = acc_cyc;
    chk("accept_interval_1", 128'(a1 - a0), 128'(12));
    track();
    offer(PT1, K1, CT1);
    chk("accept_interval_2", 128'(acc_cyc - a1), 128'(12));
    track();

    // output backpressure with the next block waiting
    out_ready = 1'b0;
    offer(PT2, K2, CT2);
    track();
    fork
      offer(PT1, K1, CT1);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_out_valid", 128'(out_valid), 128'(1));
          chk("bp_out_data", out_data, CT2);
          chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    chk("accept_after_handshake", 128'(acc_cyc - hs_cyc), 128'(1));
    track();

    // flush at round index 4, then flush outranking an offer in IDLE
    offer(PT1, K1, CT1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    chk("idx_before_flush", 128'(rnd_index), 128'(4));
    flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_busy", 128'(busy), 128'(0));
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_rnd_index", 128'(rnd_index), 128'(0));
    flush = 1'b1; in_valid = 1'b1; in_data = PT2; in_key = K2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_prio_busy", 128'(busy), 128'(0));
    chk("flush_prio_in_ready", 128'(in_ready), 128'(1));
    repeat (15) @(posedge clk); #1;
    offer(PT2, K2, CT2);
    track();

    // reset at round index 6
    offer(PT2, K2, CT2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    chk("idx_before_reset", 128'(rnd_index), 128'(6));
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_rnd_index", 128'(rnd_index), 128'(0));
    chk("mid_rst_out_data", out_data, 128'(0));
    chk("mid_rst_rnd_data", rnd_data, 128'(0));
    chk("mid_rst_rnd_key", rnd_key, 128'(0));
    rst_n = 1'b1;
    repeat (15) @(posedge clk); #1;

    // new inputs offered during RUN must be ignored
    offer(PT1, K1, CT1);
    in_valid = 1'b1; in_data = PT2; in_key = K2;
    track();
    in_valid = 1'b0;

    repeat (20) @(posedge clk); #1;
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
